// File: rtl/width_gearbox.sv
// Lane-width gearbox: unpacks a wide word into MSB-first narrow lanes (MODE=0)
// or packs narrow lanes into a wide word with a lane count (MODE=1).
module width_gearbox #(
    parameter  int unsigned NARROW_W = 8,
    parameter  int unsigned RATIO    = 4,
    parameter  int unsigned MODE     = 0,
    localparam int unsigned WIDE_W   = NARROW_W * RATIO,
    localparam int unsigned LW       = $clog2(RATIO) + 1,
    localparam int unsigned IN_W     = (MODE == 0) ? WIDE_W : NARROW_W,
    localparam int unsigned OUT_W    = (MODE == 0) ? NARROW_W : WIDE_W
) (
    input  logic             clk_4f,
    input  logic             reset,
    input  logic [IN_W-1:0]  in_data,
    input  logic [LW-1:0]    in_lanes,
    input  logic             in_last,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [OUT_W-1:0] out_data,
    output logic [LW-1:0]    out_lanes,
    output logic             out_last,
    output logic             out_valid,
    input  logic             out_ready
);

    // Holds in_ready low for the whole reset period and until the first edge after release.
    logic live_q;

    always_ff @(posedge clk_4f or negedge reset) begin
        if (!reset) live_q <= 1'b0;
        else        live_q <= 1'b1;
    end

    if (MODE == 0) begin : g_unpack
        typedef enum logic {U_IDLE, U_SHIFT} ustate_e;

        ustate_e             state_q;
        logic [WIDE_W-1:0]   word_q;
        logic [LW-1:0]       n_q;
        logic [LW-1:0]       idx_q;
        logic                last_q;
        logic [NARROW_W-1:0] data_q;
        logic                out_last_q;
        logic                out_valid_q;
        logic [LW-1:0]       n_in;
        logic [LW-1:0]       idx_nxt;
        logic                at_end;

        function automatic logic [NARROW_W-1:0] lane_of(input logic [WIDE_W-1:0] w,
                                                        input logic [LW-1:0] i);
            logic [WIDE_W-1:0] s;
            s = w << (int'(i) * NARROW_W);
            return s[WIDE_W-1 -: NARROW_W];
        endfunction

        assign n_in    = (in_lanes == '0 || in_lanes > LW'(RATIO)) ? LW'(RATIO) : in_lanes;
        assign idx_nxt = idx_q + 1'b1;
        assign at_end  = (idx_q == n_q - 1'b1);

        // Next word is taken on the same edge the final lane is consumed, so no bubble.
        assign in_ready = live_q &&
                          (state_q == U_IDLE || (out_valid_q && out_ready && at_end));

        always_ff @(posedge clk_4f or negedge reset) begin
            if (!reset) begin
                state_q     <= U_IDLE;
                word_q      <= '0;
                n_q         <= '0;
                idx_q       <= '0;
                last_q      <= 1'b0;
                data_q      <= '0;
                out_last_q  <= 1'b0;
                out_valid_q <= 1'b0;
            end else if (in_valid && in_ready) begin
                state_q     <= U_SHIFT;
                word_q      <= in_data;
                n_q         <= n_in;
                idx_q       <= '0;
                last_q      <= in_last;
                data_q      <= lane_of(in_data, '0);
                out_last_q  <= in_last && (n_in == LW'(1));
                out_valid_q <= 1'b1;
            end else if (out_valid_q && out_ready) begin
                if (at_end) begin
                    state_q     <= U_IDLE;
                    out_valid_q <= 1'b0;
                    out_last_q  <= 1'b0;
                end else begin
                    idx_q      <= idx_nxt;
                    data_q     <= lane_of(word_q, idx_nxt);
                    out_last_q <= last_q && (idx_nxt == n_q - 1'b1);
                end
            end
        end

        assign out_data  = data_q;
        assign out_lanes = LW'(live_q);
        assign out_last  = out_last_q;
        assign out_valid = out_valid_q;
    end else begin : g_pack
        logic [LW-1:0]     cnt_q;
        logic [WIDE_W-1:0] acc_q;
        logic [WIDE_W-1:0] data_q;
        logic [LW-1:0]     lanes_q;
        logic              last_q;
        logic              valid_q;
        logic              completing;
        logic [WIDE_W-1:0] lane_word;
        logic [WIDE_W-1:0] acc_d;
        logic              unused_lanes;

        assign unused_lanes = ^in_lanes;
        assign completing   = (cnt_q == LW'(RATIO - 1)) || in_last;
        assign lane_word    = {in_data, {(WIDE_W-NARROW_W){1'b0}}} >> (int'(cnt_q) * NARROW_W);
        assign acc_d        = acc_q | lane_word;

        // Only a completing beat needs the output register, so only it can be stalled.
        assign in_ready = live_q && !(completing && valid_q && !out_ready);

        always_ff @(posedge clk_4f or negedge reset) begin
            if (!reset) begin
                cnt_q   <= '0;
                acc_q   <= '0;
                data_q  <= '0;
                lanes_q <= '0;
                last_q  <= 1'b0;
                valid_q <= 1'b0;
            end else if (in_valid && in_ready && completing) begin
                data_q  <= acc_d;
                lanes_q <= cnt_q + 1'b1;
                last_q  <= in_last;
                valid_q <= 1'b1;
                acc_q   <= '0;
                cnt_q   <= '0;
            end else begin
                if (valid_q && out_ready) valid_q <= 1'b0;
                if (in_valid && in_ready) begin
                    acc_q <= acc_d;
                    cnt_q <= cnt_q + 1'b1;
                end
            end
        end

        assign out_data  = data_q;
        assign out_lanes = lanes_q;
        assign out_last  = last_q;
        assign out_valid = valid_q;
    end

endmodule

// File: tb/tb_width_gearbox.sv
// Directed bench for width_gearbox: one unpack (MODE=0) and one pack (MODE=1) instance,
// NARROW_W=8, RATIO=4, sharing clock and reset.
module tb_width_gearbox;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n;

    logic [31:0] u_in_data;
    logic [2:0]  u_in_lanes;
    logic        u_in_last, u_in_valid, u_in_ready;
    logic [7:0]  u_out_data;
    logic [2:0]  u_out_lanes;
    logic        u_out_last, u_out_valid, u_out_ready;

    logic [7:0]  p_in_data;
    logic [2:0]  p_in_lanes;
    logic        p_in_last, p_in_valid, p_in_ready;
    logic [31:0] p_out_data;
    logic [2:0]  p_out_lanes;
    logic        p_out_last, p_out_valid, p_out_ready;

    int errors = 0;
    int checks = 0;

    width_gearbox #(.NARROW_W(8), .RATIO(4), .MODE(0)) u_unp (
        .clk_4f(clk), .reset(rst_n),
        .in_data(u_in_data), .in_lanes(u_in_lanes), .in_last(u_in_last),
        .in_valid(u_in_valid), .in_ready(u_in_ready),
        .out_data(u_out_data), .out_lanes(u_out_lanes), .out_last(u_out_last),
        .out_valid(u_out_valid), .out_ready(u_out_ready)
    );

    width_gearbox #(.NARROW_W(8), .RATIO(4), .MODE(1)) u_pk (
        .clk_4f(clk), .reset(rst_n),
        .in_data(p_in_data), .in_lanes(p_in_lanes), .in_last(p_in_last),
        .in_valid(p_in_valid), .in_ready(p_in_ready),
        .out_data(p_out_data), .out_lanes(p_out_lanes), .out_last(p_out_last),
        .out_valid(p_out_valid), .out_ready(p_out_ready)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        @(negedge clk);
    endtask

    // Expects lanes 0..n-1 of an already-accepted word on consecutive cycles, then idle.
    task automatic unp_run(input string tag, input logic [31:0] word, input int n,
                           input logic lastb);
        logic [31:0] sh;
        for (int i = 0; i < n; i++) begin
            sh = word >> (24 - 8 * i);
            check($sformatf("%s_v%0d", tag, i), u_out_valid, 1);
            check($sformatf("%s_d%0d", tag, i), u_out_data, sh[7:0]);
            check($sformatf("%s_l%0d", tag, i), u_out_last, lastb && (i == n - 1));
            check($sformatf("%s_r%0d", tag, i), u_in_ready, i == n - 1);
            check($sformatf("%s_n%0d", tag, i), u_out_lanes, 1);
            tick();
        end
        check($sformatf("%s_idle_v", tag), u_out_valid, 0);
        check($sformatf("%s_idle_r", tag), u_in_ready, 1);
    endtask

    task automatic unp_send(input logic [31:0] word, input logic [2:0] lanes, input logic lastb);
        u_in_data  = word;
        u_in_lanes = lanes;
        u_in_last  = lastb;
        u_in_valid = 1'b1;
        tick();
        u_in_valid = 1'b0;
    endtask

    task automatic pk_beat(input string tag, input logic [7:0] d, input logic lastb);
        p_in_data  = d;
        p_in_last  = lastb;
        p_in_valid = 1'b1;
        check(tag, p_in_ready, 1);
        tick();
        p_in_valid = 1'b0;
        p_in_last  = 1'b0;
    endtask

    task automatic pk_out(input string tag, input logic [31:0] d, input logic [2:0] n,
                          input logic lastb);
        check({tag, "_v"}, p_out_valid, 1);
        check({tag, "_d"}, p_out_data, d);
        check({tag, "_n"}, p_out_lanes, n);
        check({tag, "_l"}, p_out_last, lastb);
    endtask

    initial begin
        int b;
        rst_n       = 1'b0;
        u_in_data   = '0; u_in_lanes = '0; u_in_last = 1'b0; u_in_valid = 1'b0;
        u_out_ready = 1'b1;
        p_in_data   = '0; p_in_lanes = '0; p_in_last = 1'b0; p_in_valid = 1'b0;
        p_out_ready = 1'b1;

        #12;
        check("rst_u_valid", u_out_valid, 0);
        check("rst_u_data",  u_out_data, 0);
        check("rst_u_lanes", u_out_lanes, 0);
        check("rst_u_ready", u_in_ready, 0);
        check("rst_p_valid", p_out_valid, 0);
        check("rst_p_data",  p_out_data, 0);
        check("rst_p_lanes", p_out_lanes, 0);
        check("rst_p_ready", p_in_ready, 0);

        @(negedge clk);
        rst_n = 1'b1;
        tick();
        check("post_rst_u_ready", u_in_ready, 1);
        check("post_rst_p_ready", p_in_ready, 1);

        // Unpack: single word, full lanes.
        unp_send(32'hDEADBEEF, 3'd4, 1'b1);
        unp_run("u_dead", 32'hDEADBEEF, 4, 1'b1);

        // Unpack: back-to-back words with in_valid held.
        u_in_data = 32'h11223344; u_in_lanes = 3'd4; u_in_last = 1'b0; u_in_valid = 1'b1;
        tick();
        u_in_data = 32'h55667788; u_in_last = 1'b1;
        for (int i = 0; i < 8; i++) begin
            logic [31:0] w;
            logic [31:0] sh;
            if (i == 4) u_in_valid = 1'b0;
            w  = (i < 4) ? 32'h11223344 : 32'h55667788;
            sh = w >> (24 - 8 * (i % 4));
            check($sformatf("u_b2b_v%0d", i), u_out_valid, 1);
            check($sformatf("u_b2b_d%0d", i), u_out_data, sh[7:0]);
            check($sformatf("u_b2b_l%0d", i), u_out_last, i == 7);
            check($sformatf("u_b2b_r%0d", i), u_in_ready, (i == 3) || (i == 7));
            tick();
        end
        check("u_b2b_idle", u_out_valid, 0);

        // Unpack: partial and clamped lane counts.
        unp_send(32'hA1B2C3D4, 3'd2, 1'b1);
        unp_run("u_l2", 32'hA1B2C3D4, 2, 1'b1);
        unp_send(32'hA1B2C3D4, 3'd0, 1'b1);
        unp_run("u_l0", 32'hA1B2C3D4, 4, 1'b1);
        unp_send(32'h0F1E2D3C, 3'd7, 1'b0);
        unp_run("u_l7", 32'h0F1E2D3C, 4, 1'b0);
        unp_send(32'h99887766, 3'd1, 1'b1);
        unp_run("u_l1", 32'h99887766, 1, 1'b1);

        // Unpack: downstream stall holds lane 0 stable.
        unp_send(32'hCAFEF00D, 3'd4, 1'b0);
        u_out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            check($sformatf("u_stall_v%0d", i), u_out_valid, 1);
            check($sformatf("u_stall_d%0d", i), u_out_data, 8'hCA);
            check($sformatf("u_stall_r%0d", i), u_in_ready, 0);
        end
        u_out_ready = 1'b1;
        unp_run("u_stall", 32'hCAFEF00D, 4, 1'b0);

        // Pack: full word, gap mid-word, then last on lane 0.
        pk_beat("p_r1", 8'h01, 1'b0);
        pk_beat("p_r2", 8'h02, 1'b0);
        tick();
        check("p_gap_v", p_out_valid, 0);
        pk_beat("p_r3", 8'h03, 1'b0);
        check("p_pre4_v", p_out_valid, 0);
        pk_beat("p_r4", 8'h04, 1'b0);
        pk_out("p_w1", 32'h01020304, 3'd4, 1'b0);
        pk_beat("p_r5", 8'h05, 1'b1);
        pk_out("p_w2", 32'h05000000, 3'd1, 1'b1);
        tick();
        check("p_w2_drain", p_out_valid, 0);

        // Pack: stream two words into a stalled output register.
        p_out_ready = 1'b0;
        p_in_valid  = 1'b1;
        p_in_last   = 1'b0;
        b = 0;
        for (int c = 0; c < 10; c++) begin
            p_in_data = 8'(8'h10 + b);
            check($sformatf("p_st_r%0d", c), p_in_ready, c < 7);
            if (c >= 4) begin
                check($sformatf("p_st_v%0d", c), p_out_valid, 1);
                check($sformatf("p_st_d%0d", c), p_out_data, 32'h10111213);
            end
            if (p_in_ready) b++;
            tick();
        end
        p_out_ready = 1'b1;
        #1;
        check("p_st_release_r", p_in_ready, 1);
        pk_out("p_st_held", 32'h10111213, 3'd4, 1'b0);
        tick();
        p_in_valid = 1'b0;
        pk_out("p_st_w2", 32'h14151617, 3'd4, 1'b0);
        tick();
        check("p_st_drain", p_out_valid, 0);

        // Reset mid-word in both instances.
        u_in_data = 32'hAABBCCDD; u_in_lanes = 3'd4; u_in_last = 1'b1; u_in_valid = 1'b1;
        p_in_data = 8'hE1; p_in_valid = 1'b1; p_in_last = 1'b0;
        tick();
        u_in_valid = 1'b0;
        p_in_data  = 8'hE2;
        tick();
        p_in_valid = 1'b0;
        check("mid_u_d", u_out_data, 8'hBB);
        #2;
        rst_n = 1'b0;
        #1;
        check("mid_rst_u_v", u_out_valid, 0);
        check("mid_rst_u_d", u_out_data, 0);
        check("mid_rst_u_l", u_out_last, 0);
        check("mid_rst_u_n", u_out_lanes, 0);
        check("mid_rst_u_r", u_in_ready, 0);
        check("mid_rst_p_v", p_out_valid, 0);
        check("mid_rst_p_d", p_out_data, 0);
        check("mid_rst_p_r", p_in_ready, 0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        check("rec_u_r", u_in_ready, 1);
        check("rec_p_r", p_in_ready, 1);
        check("rec_u_v", u_out_valid, 0);
        check("rec_p_v", p_out_valid, 0);

        unp_send(32'h01020304, 3'd4, 1'b1);
        unp_run("u_rec", 32'h01020304, 4, 1'b1);

        pk_beat("p_rec_r0", 8'hA0, 1'b0);
        pk_beat("p_rec_r1", 8'hA1, 1'b0);
        pk_beat("p_rec_r2", 8'hA2, 1'b0);
        check("p_rec_pre_v", p_out_valid, 0);
        pk_beat("p_rec_r3", 8'hA3, 1'b0);
        pk_out("p_rec", 32'hA0A1A2A3, 3'd4, 1'b0);
        tick();
        check("p_rec_drain", p_out_valid, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
